// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit. Logic ops, arithmetic ops and compares finish in one cycle.
// Shifts take one cycle per bit position, and the result is held until the consumer takes it.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state;
    logic [3:0]       ctrl_q;
    logic [4:0]       shift_cnt;
    logic [WIDTH-1:0] alu_value;
    logic [WIDTH-1:0] shift_next;
    logic             alu_illegal;
    logic             is_shift;
    logic             accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Single-cycle result for the incoming request; for shifts this is the unshifted op_a
    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        is_shift    = 1'b0;
        case (alu_ctrl)
            ALU_AND:  alu_value = op_a & op_b;
            ALU_OR:   alu_value = op_a | op_b;
            ALU_ADD:  alu_value = op_a + op_b;
            ALU_SUB:  alu_value = op_a - op_b;
            ALU_XOR:  alu_value = op_a ^ op_b;
            ALU_SLT:  alu_value = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_value = {{(WIDTH-1){1'b0}}, op_a < op_b};
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                alu_value = op_a;
                is_shift  = 1'b1;
            end
            default:  alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        shift_next = result;
        case (ctrl_q)
            ALU_SLL: shift_next = {result[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_next = {1'b0, result[WIDTH-1:1]};
            ALU_SRA: shift_next = {result[WIDTH-1], result[WIDTH-1:1]};
            default: shift_next = result;
        endcase
    end

    // The result register doubles as the shift register; zero is only computed from the final value
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            shift_cnt <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_q  <= alu_ctrl;
                        result  <= alu_value;
                        illegal <= alu_illegal;
                        if (is_shift && (op_b[4:0] != 5'd0)) begin
                            shift_cnt <= op_b[4:0];
                            zero      <= 1'b0;
                            state     <= SHIFT;
                        end else begin
                            zero  <= (alu_value == '0);
                            state <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    result    <= shift_next;
                    shift_cnt <= shift_cnt - 5'd1;
                    if (shift_cnt == 5'd1) begin
                        zero  <= (shift_next == '0);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. Stimulus pushes expected responses into a queue,
// and a monitor pops and checks each one when out_valid rises.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        int          latency;
        int          accept_cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic ready_random = 1'b0;
    logic ready_force  = 1'b1;
    logic holding = 1'b0;
    logic [31:0] held_result;
    logic        held_zero;
    logic        held_illegal;
    logic [3:0]  r_ctrl;
    logic [31:0] r_a;
    logic [31:0] r_b;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // The consumer either takes results at random or follows a level set by the main sequence
    always @(posedge clk) begin
        #1;
        out_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic il, input int lat);
        exp_t e;
        e.result       = r;
        e.zero         = z;
        e.illegal      = il;
        e.latency      = lat;
        e.accept_cycle = 0;
        return e;
    endfunction

    // Reference behaviour: plain operators, with latency of one cycle plus one per shifted bit
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh = int'(b[4:0]);
        e.illegal      = 1'b0;
        e.latency      = 1;
        e.accept_cycle = 0;
        case (c)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = a + b;
            4'b0110: e.result = a - b;
            4'b0011: e.result = a ^ b;
            4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: e.result = (a < b) ? 32'd1 : 32'd0;
            4'b0100: begin e.result = a << sh; e.latency = 1 + sh; end
            4'b0101: begin e.result = a >> sh; e.latency = 1 + sh; end
            4'b1000: begin e.result = 32'($signed(a) >>> sh); e.latency = 1 + sh; end
            default: begin e.result = 32'd0; e.illegal = 1'b1; end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int waited = 0;
        in_valid = 1'b0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        e.accept_cycle = cycle;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic drainWait();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: check each response once on arrival, then check it stays stable until it is consumed
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!holding) begin
                if (sb_q.size() == 0) begin
                    checkOutput("out_valid_without_request", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("result", result, mon_e.result);
                    checkOutput("zero", 32'(zero), 32'(mon_e.zero));
                    checkOutput("illegal", 32'(illegal), 32'(mon_e.illegal));
                    checkOutput("latency", 32'(cycle - mon_e.accept_cycle), 32'(mon_e.latency));
                end
                held_result  = result;
                held_zero    = zero;
                held_illegal = illegal;
                holding      = 1'b1;
            end else begin
                checkOutput("stable_result", result, held_result);
                checkOutput("stable_zero", 32'(zero), 32'(held_zero));
                checkOutput("stable_illegal", 32'(illegal), 32'(held_illegal));
            end
            if (out_ready === 1'b1)
                holding = 1'b0;
        end else begin
            holding = 1'b0;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        alu_ctrl = 4'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed cases with hand-derived results
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b1, 1'b0, 1));
        applyStimulus(4'b0110, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1));
        applyStimulus(4'b0111, 32'h8000_0000, 32'd1, mk(32'd1, 1'b0, 1'b0, 1));
        applyStimulus(4'b1001, 32'h8000_0000, 32'd1, mk(32'd0, 1'b1, 1'b0, 1));
        applyStimulus(4'b1000, 32'h8000_0000, 32'd4, mk(32'hF800_0000, 1'b0, 1'b0, 5));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("in_ready_during_shift", 32'(in_ready), 32'd0);
        end
        applyStimulus(4'b0100, 32'h1234_5678, 32'h0000_0020, mk(32'h1234_5678, 1'b0, 1'b0, 1));
        applyStimulus(4'b1111, 32'hDEAD_BEEF, 32'h1, mk(32'd0, 1'b1, 1'b1, 1));
        applyStimulus(4'b0101, 32'h8000_0000, 32'd31, mk(32'd1, 1'b0, 1'b0, 32));
        drainWait();

        // Backpressure: hold the AND result for several cycles while in_valid is asserted
        @(negedge clk);
        ready_force = 1'b0;
        applyStimulus(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, mk(32'h00F0_00F0, 1'b0, 1'b0, 1));
        in_valid = 1'b1;
        alu_ctrl = 4'b0001;
        op_a     = 32'h1111_1111;
        op_b     = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_result_held", result, 32'h00F0_00F0);
        @(negedge clk);
        checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
        checkOutput("bp_out_valid_after", 32'(out_valid), 32'd0);

        // Reset in the middle of a 20-step shift must abort with no response
        @(negedge clk);
        alu_ctrl = 4'b0101;
        op_a     = $urandom | 32'h8000_0000;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midshift_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midshift_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_zero", 32'(zero), 32'd0);
        checkOutput("abort_illegal", 32'(illegal), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (30) @(negedge clk);
        checkOutput("abort_no_late_valid", 32'(out_valid), 32'd0);

        // Randomized traffic with random consumer backpressure
        @(negedge clk);
        ready_random = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r_ctrl = 4'($urandom_range(0, 15));
            r_a    = $urandom;
            r_b    = $urandom;
            if ($urandom_range(0, 3) == 0)
                r_b[4:0] = 5'd0;
            if ($urandom_range(0, 3) == 0)
                r_a = r_b;
            applyStimulus(r_ctrl, r_a, r_b, model(r_ctrl, r_a, r_b));
        end
        @(negedge clk);
        ready_random = 1'b0;
        ready_force  = 1'b1;
        drainWait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
